vending_machine_change: RTL and testbench

- Parametrised successor to the no-change vending controller.
- Accumulates coin credit in unit steps (1 unit = 5 Rs) and vends one bottle when credit reaches the price.
- Returns overpayment as serial single-unit change pulses.
- Also supports cancel/refund, tracks stock and rejects coins it cannot accept.
- Sits between the coin acceptor front-end and the dispenser/changer actuators.

---
 rtl/vending_machine_change.sv | 113 +++++++++++
 tb/tb_vending_machine_change.sv | 170 +++++++++++++++++
 2 files changed

// File: rtl/vending_machine_change.sv
// Vending controller with credit accumulation, vend, serial change,
// cancel/refund, stock tracking and coin rejection.
module vending_machine_change #(
   parameter int PRICE      = 3,
   parameter int CREDIT_W   = 4,
   parameter int STOCK_W    = 4,
   parameter int STOCK_INIT = 8
) (
   input  logic                clk,
   input  logic                rst,
   input  logic [1:0]          coin,
   input  logic                cancel,
   input  logic                restock,
   output logic                out_bottle,
   output logic                out_change,
   output logic                coin_rej,
   output logic                busy,
   output logic                sold_out,
   output logic [CREDIT_W-1:0] credit,
   output logic [STOCK_W-1:0]  stock
);

   typedef enum logic [1:0] {IDLE, ACCUM, VEND, CHANGE} state_t;

   // one spare bit above the wider of credit and coin value catches overflow
   localparam int SW = ((CREDIT_W > 3) ? CREDIT_W : 3) + 1;
   localparam logic [SW-1:0]       CMAX      = SW'((1 << CREDIT_W) - 1);
   localparam logic [SW-1:0]       PRICE_S   = SW'(PRICE);
   localparam logic [CREDIT_W-1:0] PRICE_C   = CREDIT_W'(PRICE);
   localparam logic [CREDIT_W-1:0] ONE_C     = CREDIT_W'(1);
   localparam logic [STOCK_W-1:0]  STOCK_RST = STOCK_W'(STOCK_INIT);
   localparam logic [STOCK_W-1:0]  ONE_S     = STOCK_W'(1);

   state_t              state, state_n;
   logic [CREDIT_W-1:0] credit_n;
   logic [STOCK_W-1:0]  stock_n;
   logic [SW-1:0]       v, sum;
   logic                rej_n, coin_ok, has_coin;

   always_comb begin
      v = '0;
      case (coin)
         2'b01:   v = SW'(1);
         2'b10:   v = SW'(2);
         2'b11:   v = SW'(4);
         default: v = '0;
      endcase
   end

   assign has_coin = (coin != 2'b00);
   assign sum      = SW'(credit) + v;
   assign coin_ok  = (stock != '0) && (sum <= CMAX);

   always_comb begin
      state_n  = state;
      credit_n = credit;
      stock_n  = stock;
      rej_n    = 1'b0;
      unique case (state)
         IDLE, ACCUM: begin
            if (state == ACCUM && cancel) begin
               state_n = CHANGE;
               rej_n   = has_coin;
            end else begin
               if (state == IDLE && restock)
                  stock_n = STOCK_RST;
               if (has_coin) begin
                  if (coin_ok) begin
                     credit_n = sum[CREDIT_W-1:0];
                     state_n  = (sum >= PRICE_S) ? VEND : ACCUM;
                  end else begin
                     rej_n = 1'b1;
                  end
               end
            end
         end
         VEND: begin
            credit_n = credit - PRICE_C;
            stock_n  = stock - ONE_S;
            state_n  = (credit_n != '0) ? CHANGE : IDLE;
            rej_n    = has_coin;
         end
         CHANGE: begin
            credit_n = credit - ONE_C;
            state_n  = (credit == ONE_C) ? IDLE : CHANGE;
            rej_n    = has_coin;
         end
      endcase
   end

   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         state      <= IDLE;
         credit     <= '0;
         stock      <= STOCK_RST;
         out_bottle <= 1'b0;
         out_change <= 1'b0;
         coin_rej   <= 1'b0;
         busy       <= 1'b0;
         sold_out   <= (STOCK_INIT == 0);
      end else begin
         state      <= state_n;
         credit     <= credit_n;
         stock      <= stock_n;
         out_bottle <= (state_n == VEND);
         out_change <= (state_n == CHANGE);
         coin_rej   <= rej_n;
         busy       <= (state_n == VEND) || (state_n == CHANGE);
         sold_out   <= (stock == '0);
      end
   end

endmodule

// File: tb/tb_vending_machine_change.sv
// Directed bench for vending_machine_change across three parameter sets.
module tb_vending_machine_change;

   logic clk = 1'b0;
   always #5 clk = ~clk;

   int checks = 0;
   int failures = 0;

   // u0: defaults, u1: STOCK_INIT=1, u2: CREDIT_W=3 PRICE=7
   logic       rst0, cancel0, restock0;
   logic [1:0] coin0;
   logic       bot0, chg0, rej0, busy0, so0;
   logic [3:0] cr0, st0;

   logic       rst1, cancel1, restock1;
   logic [1:0] coin1;
   logic       bot1, chg1, rej1, busy1, so1;
   logic [3:0] cr1, st1;

   logic       rst2, cancel2, restock2;
   logic [1:0] coin2;
   logic       bot2, chg2, rej2, busy2, so2;
   logic [2:0] cr2;
   logic [3:0] st2;

   vending_machine_change u0 (
      .clk(clk), .rst(rst0), .coin(coin0), .cancel(cancel0),
      .restock(restock0), .out_bottle(bot0), .out_change(chg0),
      .coin_rej(rej0), .busy(busy0), .sold_out(so0),
      .credit(cr0), .stock(st0));

   vending_machine_change #(.STOCK_INIT(1)) u1 (
      .clk(clk), .rst(rst1), .coin(coin1), .cancel(cancel1),
      .restock(restock1), .out_bottle(bot1), .out_change(chg1),
      .coin_rej(rej1), .busy(busy1), .sold_out(so1),
      .credit(cr1), .stock(st1));

   vending_machine_change #(.CREDIT_W(3), .PRICE(7)) u2 (
      .clk(clk), .rst(rst2), .coin(coin2), .cancel(cancel2),
      .restock(restock2), .out_bottle(bot2), .out_change(chg2),
      .coin_rej(rej2), .busy(busy2), .sold_out(so2),
      .credit(cr2), .stock(st2));

   task automatic chk(input string tag, input logic [31:0] obs,
                      input logic [31:0] exp);
      checks++;
      assert (obs === exp) else begin
         failures++;
         $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
      end
   endtask

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   initial begin
      rst0 = 0; rst1 = 0; rst2 = 0;
      coin0 = 0; coin1 = 0; coin2 = 0;
      cancel0 = 0; cancel1 = 0; cancel2 = 0;
      restock0 = 0; restock1 = 0; restock2 = 0;
      #12;
      chk("rst_credit", cr0, 0);
      chk("rst_stock", st0, 8);
      chk("rst_outs", {bot0, chg0, rej0, busy0, so0}, 0);
      chk("rst_stock1", st1, 1);
      chk("rst_so1", so1, 0);
      @(posedge clk); #1;
      rst0 = 1; rst1 = 1; rst2 = 1;

      // exact price: 1 + 2
      coin0 = 2'b01; tick();
      chk("ex_cr1", cr0, 1);
      chk("ex_bot_early", bot0, 0);
      coin0 = 2'b10; tick();
      chk("ex_cr3", cr0, 3);
      chk("ex_bot_busy", {bot0, busy0}, 2'b11);
      coin0 = 2'b00; tick();
      chk("ex_after", {bot0, chg0, busy0}, 0);
      chk("ex_cr0", cr0, 0);
      chk("ex_stock7", st0, 7);
      tick();
      chk("ex_idle", {chg0, busy0}, 0);

      // overpay 2 + 2 -> one change pulse
      coin0 = 2'b10; tick();
      chk("op_cr2", cr0, 2);
      tick();
      chk("op_cr4_bot", {cr0, bot0}, {4'd4, 1'b1});
      coin0 = 2'b00; tick();
      chk("op_chg", {bot0, chg0, busy0}, 3'b011);
      chk("op_cr1_st6", {cr0, st0}, {4'd1, 4'd6});
      tick();
      chk("op_done", {chg0, busy0, cr0}, 0);

      // 4-unit coin from IDLE, coin during VEND rejected
      coin0 = 2'b11; tick();
      chk("bz_bot", {bot0, cr0}, {1'b1, 4'd4});
      coin0 = 2'b01; tick();
      chk("bz_rej_chg", {rej0, chg0, cr0}, {2'b11, 4'd1});
      coin0 = 2'b00; tick();
      chk("bz_end", {rej0, chg0, cr0}, 0);
      tick();
      chk("bz_one_pulse", {chg0, busy0}, 0);
      chk("bz_stock5", st0, 5);

      // cancel refunds 2 units
      coin0 = 2'b01; tick(); tick();
      chk("cn_cr2", cr0, 2);
      coin0 = 2'b00; cancel0 = 1; tick();
      chk("cn_c1", {bot0, chg0, busy0, cr0}, {3'b011, 4'd2});
      cancel0 = 0; tick();
      chk("cn_c2", {bot0, chg0, cr0}, {2'b01, 4'd1});
      tick();
      chk("cn_done", {chg0, busy0, cr0, st0}, {2'b00, 4'd0, 4'd5});

      // cancel with coin in ACCUM: coin rejected, full refund
      coin0 = 2'b01; tick();
      coin0 = 2'b10; cancel0 = 1; tick();
      chk("cc_rej", {rej0, chg0, cr0}, {2'b11, 4'd1});
      coin0 = 2'b00; cancel0 = 0; tick();
      chk("cc_done", {rej0, chg0, bot0, cr0, st0}, {3'b000, 4'd0, 4'd5});

      // sold out and restock
      coin1 = 2'b11; tick();
      chk("so_bot", {bot1, cr1}, {1'b1, 4'd4});
      coin1 = 2'b00; tick();
      chk("so_st0", {st1, chg1}, {4'd0, 1'b1});
      tick();
      chk("so_flag", {so1, cr1}, {1'b1, 4'd0});
      coin1 = 2'b01; tick();
      chk("so_rej", {rej1, cr1, bot1}, {1'b1, 4'd0, 1'b0});
      coin1 = 2'b00; restock1 = 1; tick();
      chk("rs_stock", st1, 1);
      restock1 = 0; tick();
      chk("rs_so", {so1, rej1}, 0);

      // saturation at CREDIT_MAX=7
      coin2 = 2'b11; tick();
      coin2 = 2'b10; tick();
      chk("sat_cr6", cr2, 6);
      coin2 = 2'b11; tick();
      chk("sat_rej", {rej2, cr2}, {1'b1, 3'd6});
      coin2 = 2'b01; tick();
      chk("sat_vend7", {bot2, cr2, rej2}, {1'b1, 3'd7, 1'b0});
      coin2 = 2'b00; tick();
      chk("sat_nochg", {chg2, cr2, st2}, {1'b0, 3'd0, 4'd7});

      // async reset mid-CHANGE
      coin2 = 2'b11; tick();
      coin2 = 2'b10; tick();
      coin2 = 2'b00; cancel2 = 1; tick();
      cancel2 = 0; tick();
      chk("ar_pre", {chg2, cr2}, {1'b1, 3'd5});
      #2 rst2 = 0;
      #1;
      chk("ar_outs", {bot2, chg2, rej2, busy2, so2}, 0);
      chk("ar_cr_st", {cr2, st2}, {3'd0, 4'd8});
      tick();
      rst2 = 1;
      tick();
      chk("ar_idle", {chg2, busy2, cr2}, 0);

      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

endmodule
